// File: rtl/mac_feed_if.sv
// Signal bundle between the MAC operand sequencer (master) and the FIFO/MAC datapath (slave).
// wren and rden are single-cycle strobes that are already qualified by full/empty in the same cycle; every strobe high at a rising clk edge is exactly one transfer.
interface mac_feed_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  start;
    logic [DATA_WIDTH-1:0] a_seed;
    logic [DATA_WIDTH-1:0] b_seed;
    logic                  full_a;
    logic                  full_b;
    logic                  empty_a;
    logic                  empty_b;
    logic                  wren;
    logic [DATA_WIDTH-1:0] wdata_a;
    logic [DATA_WIDTH-1:0] wdata_b;
    logic                  rden;
    logic                  mac_en;
    logic                  mac_clr;
    logic                  done;

    modport master (
        input  start, a_seed, b_seed, full_a, full_b, empty_a, empty_b,
        output wren, wdata_a, wdata_b, rden, mac_en, mac_clr, done
    );

    modport slave (
        output start, a_seed, b_seed, full_a, full_b, empty_a, empty_b,
        input  wren, wdata_a, wdata_b, rden, mac_en, mac_clr, done
    );
endinterface

// File: rtl/mac_feed_ctrl.sv
// Operand sequencer: fills FIFO A/B with two arithmetic streams, drains them in lockstep
// into the MAC, waits for the MAC pipeline to settle, then holds done until start drops.
module mac_feed_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int MAC_LAT    = 1
) (
    input  logic       clk,
    input  logic       rst,
    mac_feed_if.master bus,
    output logic [2:0] state_dbg
);
    localparam int IW = $clog2(DEPTH) + 1;
    localparam int CW = $clog2(MAC_LAT + 1) + 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(DEPTH - 1);
    localparam logic [IW-1:0] IDX_MAX  = IW'(DEPTH);
    localparam logic [CW-1:0] LAT_LOAD = CW'(MAC_LAT);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]    state, state_nx;
    logic [IW-1:0] idx, idx_nx;
    logic [CW-1:0] lat_cnt, lat_cnt_nx;
    logic          wr_ok, rd_ok;

    // Both FIFOs are always written or read together so their contents stay paired.
    assign wr_ok = (state == S_FILL)  && !bus.full_a  && !bus.full_b  && (idx < IDX_MAX);
    assign rd_ok = (state == S_DRAIN) && !bus.empty_a && !bus.empty_b && (idx < IDX_MAX);

    assign bus.wren    = wr_ok;
    assign bus.rden    = rd_ok;
    assign bus.wdata_a = bus.a_seed + DATA_WIDTH'(idx);
    assign bus.wdata_b = bus.b_seed + DATA_WIDTH'(idx);
    assign state_dbg   = state;

    always_comb begin
        state_nx   = state;
        idx_nx     = idx;
        lat_cnt_nx = lat_cnt;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nx = S_FILL;
                    idx_nx   = '0;
                end
            end
            S_FILL: begin
                if (wr_ok) begin
                    if (idx == IDX_LAST) begin
                        state_nx = S_DRAIN;
                        idx_nx   = '0;
                    end else begin
                        idx_nx = idx + IW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (rd_ok) begin
                    if (idx == IDX_LAST) begin
                        state_nx   = S_FLUSH;
                        idx_nx     = '0;
                        lat_cnt_nx = LAT_LOAD;
                    end else begin
                        idx_nx = idx + IW'(1);
                    end
                end
            end
            S_FLUSH: begin
                // The final mac_en fires in the first FLUSH cycle; done follows MAC_LAT cycles later.
                if (lat_cnt <= CW'(1)) begin
                    state_nx = S_DONE;
                end else begin
                    lat_cnt_nx = lat_cnt - CW'(1);
                end
            end
            S_DONE: begin
                if (!bus.start) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
                idx_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            idx         <= '0;
            lat_cnt     <= '0;
            bus.mac_en  <= 1'b0;
            bus.mac_clr <= 1'b0;
            bus.done    <= 1'b0;
        end else begin
            state       <= state_nx;
            idx         <= idx_nx;
            lat_cnt     <= lat_cnt_nx;
            // FIFO read data lands one cycle after rden, so the MAC enable trails it by one.
            bus.mac_en  <= rd_ok;
            bus.mac_clr <= (state == S_IDLE) && bus.start;
            bus.done    <= (state_nx == S_DONE);
        end
    end
endmodule

// File: tb/tb_mac_feed_ctrl.sv
// Directed bench for mac_feed_ctrl: ideal FIFO/MAC models, write-data scoreboard, per-run checks.
module tb_mac_feed_ctrl;
  localparam int DW      = 8;
  localparam int DEPTH   = 8;
  localparam int MAC_LAT = 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] state_dbg;
  always #5 clk = ~clk;

  mac_feed_if #(.DATA_WIDTH(DW)) bus ();

  mac_feed_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .MAC_LAT(MAC_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [2*DW-1:0] exp_q[$];

  // FIFO and MAC models
  logic [DW-1:0] fa[$];
  logic [DW-1:0] fb[$];
  int lvl_a = 0;
  int lvl_b = 0;
  logic force_full_b  = 1'b0;
  logic force_empty_a = 1'b0;
  logic [DW-1:0] rd_a = '0;
  logic [DW-1:0] rd_b = '0;
  int acc = 0;

  int wr_cnt = 0;
  int rd_cnt = 0;
  int en_cnt = 0;
  int clr_cnt = 0;
  logic prev_rden = 1'b0;

  assign bus.full_a  = (lvl_a >= DEPTH);
  assign bus.full_b  = force_full_b || (lvl_b >= DEPTH);
  assign bus.empty_a = force_empty_a || (lvl_a == 0);
  assign bus.empty_b = (lvl_b == 0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      fa.delete();
      fb.delete();
      acc = 0;
    end else begin
      if (bus.mac_clr) acc = 0;
      if (bus.mac_en) acc = acc + int'(rd_a) * int'(rd_b);
      if (bus.rden && fa.size() > 0 && fb.size() > 0) begin
        rd_a = fa.pop_front();
        rd_b = fb.pop_front();
      end
      if (bus.wren) begin
        fa.push_back(bus.wdata_a);
        fb.push_back(bus.wdata_b);
      end
    end
    lvl_a <= fa.size();
    lvl_b <= fb.size();
  end

  // monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (bus.wren) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL wdata: got unexpected write 0x%0h/0x%0h, expected no write", bus.wdata_a, bus.wdata_b);
        end else begin
          check("wdata", {bus.wdata_a, bus.wdata_b}, exp_q.pop_front());
        end
      end
      if (bus.rden) rd_cnt++;
      if (bus.mac_en) en_cnt++;
      if (bus.mac_clr) clr_cnt++;
      if (bus.mac_en || prev_rden) check("mac_en_after_rden", bus.mac_en, prev_rden);
      if (bus.wren || bus.rden) check("wren_rden_exclusive", bus.wren && bus.rden, 0);
      prev_rden = bus.rden && !rst;
    end
  end

  // driver tasks
  task automatic do_reset(input int n);
    rst = 1'b1;
    bus.start = 1'b1;
    repeat (n) begin
      @(negedge clk);
      #2;
      check("reset_outputs", {bus.wren, bus.rden, bus.mac_en, bus.mac_clr, bus.done}, 0);
      check("reset_state", state_dbg, 0);
    end
    bus.start = 1'b0;
    rst = 1'b0;
  endtask

  task automatic run(input logic [DW-1:0] a_s, input logic [DW-1:0] b_s,
                     input int fill_stall, input int drain_stall,
                     input int abort_after, input int hold);
    int cyc = 0;
    int wr_seen = 0;
    int rd_seen = 0;
    int fs_left = fill_stall;
    int ds_left = drain_stall;
    int exp_sum = 0;
    bit got_done = 1'b0;
    logic [DW-1:0] ea, eb;
    for (int i = 0; i < DEPTH; i++) begin
      ea = a_s + DW'(i);
      eb = b_s + DW'(i);
      exp_q.push_back({ea, eb});
      exp_sum += int'(ea) * int'(eb);
    end
    @(negedge clk);
    bus.a_seed = a_s;
    bus.b_seed = b_s;
    bus.start  = 1'b1;
    wr_cnt = 0; rd_cnt = 0; en_cnt = 0; clr_cnt = 0;
    while (cyc < 200) begin
      @(negedge clk);
      force_full_b = (wr_seen == 2) && (fs_left > 0);
      if (force_full_b) fs_left--;
      force_empty_a = (rd_seen == 4) && (ds_left > 0);
      if (force_empty_a) ds_left--;
      if (abort_after > 0 && rd_seen == abort_after) begin
        rst = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        #2;
        check("abort_outputs", {bus.wren, bus.rden, bus.mac_en, bus.mac_clr, bus.done}, 0);
        check("abort_state", state_dbg, 0);
        rst = 1'b0;
        return;
      end
      #2;
      cyc++;
      if (bus.wren) wr_seen++;
      if (bus.rden) rd_seen++;
      if (bus.done) begin
        got_done = 1'b1;
        break;
      end
    end
    check("done_seen", got_done, 1);
    check("done_latency", cyc, 2 * DEPTH + 1 + MAC_LAT + fill_stall + drain_stall);
    check("wren_count", wr_cnt, DEPTH);
    check("rden_count", rd_cnt, DEPTH);
    check("mac_en_count", en_cnt, DEPTH);
    check("mac_clr_count", clr_cnt, 1);
    check("mac_sum", acc, exp_sum);
    repeat (hold) begin
      @(negedge clk);
      #2;
      check("done_held", {bus.done, state_dbg}, {1'b1, 3'd4});
    end
    if (hold > 0) check("no_rerun_writes", wr_cnt, DEPTH);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    #2;
    check("done_falls", {bus.done, state_dbg}, {1'b0, 3'd0});
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.a_seed = '0;
    bus.b_seed = '0;
    do_reset(3);
    run(8'd1, 8'd1, 0, 0, 0, 3);
    check("mac_sum_204", acc, 204);
    run(8'hFE, 8'h00, 0, 0, 0, 0);
    run(8'd1, 8'd1, 3, 0, 0, 0);
    run(8'd1, 8'd1, 0, 2, 0, 0);
    run(8'd1, 8'd1, 0, 0, 4, 0);
    run(8'd3, 8'd5, 0, 0, 0, 0);
    check("exp_q_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
